// File: rtl/processor.sv
// processor -- single-cycle 32-bit core for the MIPS-style teaching ISA.
//
// Holds only the PC register, the instruction decode and the ALU. Instruction
// memory, data memory and the register file live outside and are accessed
// combinationally within the same cycle. Their writes commit on the same
// rising edge that advances the PC.
//
// Ports
//   clock, reset        master clock; synchronous active-high reset
//   out_PC, in_PC       current PC and the value loaded at the next edge
//   address_imem/q_imem instruction fetch (address = PC)
//   address_dmem/data/wren/q_dmem   data memory access (sw writes, lw reads)
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg   regfile write port
//   ctrl_readRegA/B, data_readRegA/B                regfile read ports
module processor (
    input  logic        clock,
    input  logic        reset,
    output logic [11:0] out_PC,
    output logic [11:0] in_PC,
    output logic [11:0] address_imem,
    input  logic [31:0] q_imem,
    output logic [11:0] address_dmem,
    output logic [31:0] data,
    output logic        wren,
    input  logic [31:0] q_dmem,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_writeReg,
    input  logic [31:0] data_readRegA,
    input  logic [31:0] data_readRegB
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SRA  = 5'b00101;

    // Overflow status codes written to r30 in place of the real result.
    localparam logic [4:0]  OVF_REG       = 5'd30;
    localparam logic [31:0] OVF_CODE_ADD  = 32'd1;
    localparam logic [31:0] OVF_CODE_ADDI = 32'd2;
    localparam logic [31:0] OVF_CODE_SUB  = 32'd3;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [4:0]  aluop;
        logic [31:0] imm;   // sign-extended imm[16:0]
    } dec_t;

    logic [11:0] pc;
    dec_t        dec;

    // ------------------------------------------------------------------
    // PC register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) pc <= 12'd0;
        else       pc <= pc + 12'd1;   // wraps 4095 -> 0 naturally
    end

    assign out_PC       = pc;
    assign address_imem = pc;
    assign in_PC        = reset ? 12'd0 : pc + 12'd1;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    always_comb begin
        dec.opcode = q_imem[31:27];
        dec.rd     = q_imem[26:22];
        dec.rs     = q_imem[21:17];
        dec.rt     = q_imem[16:12];
        dec.shamt  = q_imem[11:7];
        dec.aluop  = q_imem[6:2];
        dec.imm    = {{15{q_imem[16]}}, q_imem[16:0]};
    end

    logic is_r, is_addi, is_sw, is_lw;
    assign is_r    = (dec.opcode == OP_RTYPE);
    assign is_addi = (dec.opcode == OP_ADDI);
    assign is_sw   = (dec.opcode == OP_SW);
    assign is_lw   = (dec.opcode == OP_LW);

    // sw reads the value to store through port B using the rd field.
    assign ctrl_readRegA = dec.rs;
    assign ctrl_readRegB = is_sw ? dec.rd : dec.rt;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [31:0] op_a, op_b, alu_res;
    logic        r_valid, ovf;

    assign op_a = data_readRegA;
    assign op_b = is_r ? data_readRegB : dec.imm;

    always_comb begin
        alu_res = 32'd0;
        r_valid = 1'b1;
        ovf     = 1'b0;
        if (is_r) begin
            case (dec.aluop)
                ALU_ADD: begin
                    alu_res = op_a + op_b;
                    ovf     = (op_a[31] == op_b[31]) && (alu_res[31] != op_a[31]);
                end
                ALU_SUB: begin
                    alu_res = op_a - op_b;
                    ovf     = (op_a[31] != op_b[31]) && (alu_res[31] != op_a[31]);
                end
                ALU_AND: alu_res = op_a & op_b;
                ALU_OR:  alu_res = op_a | op_b;
                ALU_SLL: alu_res = op_a << dec.shamt;
                ALU_SRA: alu_res = $unsigned($signed(op_a) >>> dec.shamt);
                default: r_valid = 1'b0;
            endcase
        end else begin
            // addi, lw and sw all form rs + sext(imm); only addi flags overflow.
            alu_res = op_a + op_b;
            ovf     = is_addi && (op_a[31] == op_b[31]) && (alu_res[31] != op_a[31]);
        end
    end

    assign address_dmem = alu_res[11:0];
    assign data         = data_readRegB;

    // ------------------------------------------------------------------
    // Writeback / memory control
    // ------------------------------------------------------------------
    logic        wr_inst;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    assign wr_inst = (is_r && r_valid) || is_addi || is_lw;

    always_comb begin
        wb_reg  = dec.rd;
        wb_data = is_lw ? q_dmem : alu_res;
        if (ovf) begin
            wb_reg = OVF_REG;
            if (is_addi)                   wb_data = OVF_CODE_ADDI;
            else if (dec.aluop == ALU_SUB) wb_data = OVF_CODE_SUB;
            else                           wb_data = OVF_CODE_ADD;
        end
    end

    assign ctrl_writeReg    = wb_reg;
    assign data_writeReg    = wb_data;
    // r0 writes are dropped unless redirected to r30 by overflow.
    assign ctrl_writeEnable = !reset && wr_inst && (wb_reg != 5'd0);
    assign wren             = !reset && is_sw;

endmodule

// File: tb/tb_processor.sv
// Directed bench for processor: the bench plays imem, dmem and regfile by
// driving q_imem, q_dmem and data_readRegA/B, then checks decode outputs.
module tb_processor;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] out_PC, in_PC, address_imem, address_dmem;
    logic [31:0] q_imem, q_dmem, data, data_writeReg, data_readRegA, data_readRegB;
    logic        wren, ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;

    int n_tests = 0;
    int n_fail  = 0;

    processor dut (
        .clock(clock), .reset(reset),
        .out_PC(out_PC), .in_PC(in_PC), .address_imem(address_imem),
        .q_imem(q_imem), .address_dmem(address_dmem), .data(data),
        .wren(wren), .q_dmem(q_dmem),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_writeReg(data_writeReg),
        .data_readRegA(data_readRegA), .data_readRegB(data_readRegB)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, rs, rt, shamt, aluop);
        return {5'b00000, rd, rs, rt, shamt, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, rd, rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Apply inputs away from the clock edge and let the combinational path settle.
    task automatic apply(input logic [31:0] instr, input logic [31:0] a, b, dq);
        q_imem = instr; data_readRegA = a; data_readRegB = b; q_dmem = dq;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    logic [11:0] pc_before;

    initial begin
        reset = 1'b1;
        // sw during reset would otherwise assert wren; add would assert write enable
        apply(itype(5'd7, 5'd2, 5'd1, 17'd8), 32'd4, 32'd1, 32'd0);
        tick(); tick();
        chk("rst_pc",     {20'd0, out_PC}, 32'd0);
        chk("rst_imem",   {20'd0, address_imem}, 32'd0);
        chk("rst_in_pc",  {20'd0, in_PC}, 32'd0);
        chk("rst_wren",   {31'd0, wren}, 32'd0);
        apply(32'h00C22000, 32'd5, 32'd7, 32'd0);
        chk("rst_we",     {31'd0, ctrl_writeEnable}, 32'd0);

        // release and step 0,1,2
        reset = 1'b0;
        #1;
        chk("rel_in_pc",  {20'd0, in_PC}, 32'd1);
        tick();
        chk("step1",      {20'd0, out_PC}, 32'd1);
        chk("step1_in",   {20'd0, in_PC}, 32'd2);
        tick();
        chk("step2",      {20'd0, out_PC}, 32'd2);
        chk("step2_imem", {20'd0, address_imem}, 32'd2);

        // add r3,r1,r2
        apply(32'h00C22000, 32'd5, 32'd7, 32'd0);
        chk("add_we",   {31'd0, ctrl_writeEnable}, 32'd1);
        chk("add_reg",  {27'd0, ctrl_writeReg}, 32'd3);
        chk("add_rA",   {27'd0, ctrl_readRegA}, 32'd1);
        chk("add_rB",   {27'd0, ctrl_readRegB}, 32'd2);
        chk("add_data", data_writeReg, 32'd12);
        chk("add_wren", {31'd0, wren}, 32'd0);
        apply(32'h00C22000, 32'h7FFFFFFF, 32'd1, 32'd0);
        chk("addovf_reg",  {27'd0, ctrl_writeReg}, 32'd30);
        chk("addovf_data", data_writeReg, 32'd1);
        chk("addovf_we",   {31'd0, ctrl_writeEnable}, 32'd1);
        tick();

        // sub overflow, shifts, logic
        apply(rtype(5'd5, 5'd1, 5'd2, 5'd0, 5'd1), 32'h80000000, 32'd1, 32'd0);
        chk("subovf_reg",  {27'd0, ctrl_writeReg}, 32'd30);
        chk("subovf_data", data_writeReg, 32'd3);
        apply(rtype(5'd5, 5'd1, 5'd2, 5'd0, 5'd1), 32'd10, 32'd3, 32'd0);
        chk("sub_data", data_writeReg, 32'd7);
        chk("sub_reg",  {27'd0, ctrl_writeReg}, 32'd5);
        apply(rtype(5'd6, 5'd1, 5'd2, 5'd4, 5'd4), 32'h1, 32'hFFFF, 32'd0);
        chk("sll", data_writeReg, 32'h10);
        apply(rtype(5'd6, 5'd1, 5'd2, 5'd4, 5'd5), 32'hF0000000, 32'd0, 32'd0);
        chk("sra", data_writeReg, 32'hFF000000);
        apply(rtype(5'd7, 5'd1, 5'd2, 5'd0, 5'd2), 32'hF0F0, 32'h0FF0, 32'd0);
        chk("and", data_writeReg, 32'h00F0);
        apply(rtype(5'd7, 5'd1, 5'd2, 5'd0, 5'd3), 32'hF0F0, 32'h0FF0, 32'd0);
        chk("or",  data_writeReg, 32'hFFF0);
        tick();

        // addi
        apply(itype(5'd5, 5'd4, 5'd1, 17'h1FFFF), 32'd10, 32'hFFFF, 32'd0);
        chk("addi_data", data_writeReg, 32'd9);
        chk("addi_reg",  {27'd0, ctrl_writeReg}, 32'd4);
        chk("addi_we",   {31'd0, ctrl_writeEnable}, 32'd1);
        apply(itype(5'd5, 5'd4, 5'd1, 17'd1), 32'h7FFFFFFF, 32'd0, 32'd0);
        chk("addiovf_reg",  {27'd0, ctrl_writeReg}, 32'd30);
        chk("addiovf_data", data_writeReg, 32'd2);
        tick();

        // sw / lw
        apply(itype(5'd7, 5'd2, 5'd1, 17'd8), 32'd4, 32'hDEAD, 32'd0);
        chk("sw_rB",   {27'd0, ctrl_readRegB}, 32'd2);
        chk("sw_addr", {20'd0, address_dmem}, 32'd12);
        chk("sw_data", data, 32'hDEAD);
        chk("sw_wren", {31'd0, wren}, 32'd1);
        chk("sw_we",   {31'd0, ctrl_writeEnable}, 32'd0);
        tick();
        apply(itype(5'd8, 5'd6, 5'd1, 17'd8), 32'd4, 32'd0, 32'hBEEF);
        chk("lw_addr", {20'd0, address_dmem}, 32'd12);
        chk("lw_data", data_writeReg, 32'hBEEF);
        chk("lw_reg",  {27'd0, ctrl_writeReg}, 32'd6);
        chk("lw_we",   {31'd0, ctrl_writeEnable}, 32'd1);
        chk("lw_wren", {31'd0, wren}, 32'd0);

        // illegal opcode and illegal aluop: no writes, PC still advances
        apply(32'hF8C22000, 32'd5, 32'd7, 32'd0);
        chk("ill_we",   {31'd0, ctrl_writeEnable}, 32'd0);
        chk("ill_wren", {31'd0, wren}, 32'd0);
        pc_before = out_PC;
        tick();
        chk("ill_pc", {20'd0, out_PC}, {20'd0, pc_before + 12'd1});
        apply(rtype(5'd3, 5'd1, 5'd2, 5'd0, 5'd7), 32'd5, 32'd7, 32'd0);
        chk("badalu_we", {31'd0, ctrl_writeEnable}, 32'd0);

        // add with rd = 0
        apply(rtype(5'd0, 5'd1, 5'd2, 5'd0, 5'd0), 32'd5, 32'd7, 32'd0);
        chk("r0_we", {31'd0, ctrl_writeEnable}, 32'd0);
        apply(rtype(5'd0, 5'd1, 5'd2, 5'd0, 5'd0), 32'h7FFFFFFF, 32'd1, 32'd0);
        chk("r0ovf_we", {31'd0, ctrl_writeEnable}, 32'd1);

        // mid-program reset: PC back to 0, writes suppressed
        reset = 1'b1;
        apply(32'h00C22000, 32'd5, 32'd7, 32'd0);
        chk("mid_rst_we",  {31'd0, ctrl_writeEnable}, 32'd0);
        chk("mid_rst_in",  {20'd0, in_PC}, 32'd0);
        tick();
        chk("mid_rst_pc",  {20'd0, out_PC}, 32'd0);
        reset = 1'b0;

        // wrap: 4095 edges from PC 0 reach 4095, next edge -> 0
        repeat (4095) @(posedge clock);
        #2;
        chk("pc_4095",    {20'd0, out_PC}, 32'd4095);
        chk("in_pc_wrap", {20'd0, in_PC}, 32'd0);
        tick();
        chk("pc_wrap",    {20'd0, out_PC}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/processor.md
# processor

Single-cycle 32-bit integer core for the MIPS-style teaching ISA. Fetches one instruction per clock from an external instruction memory, reads operands from an external register file, executes in an internal ALU, and writes results back to the register file or to an external data memory. The top-level wrapper instantiates it alongside imem, dmem and the regfile. It contains only the PC register, decode and ALU.

## Interface
- No parameters.
- clock  in  1  master clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- out_PC  out  12  current PC (register value); equals address_imem.
- in_PC  out  12  next-PC value loaded at the next rising edge (PC+1 mod 4096; 0 while reset).
- address_imem  out  12  instruction address = PC.
- q_imem  in  32  instruction at address_imem, valid combinationally in the same cycle.
- address_dmem  out  12  data address = ALU result[11:0].
- data  out  32  store data = data_readRegB.
- wren  out  1  dmem write enable (sw only).
- q_dmem  in  32  load data, valid combinationally in the same cycle.
- ctrl_writeEnable  out  1  regfile write enable.
- ctrl_writeReg  out  5  destination register.
- ctrl_readRegA  out  5  source register A (rs).
- ctrl_readRegB  out  5  source register B (rt, or rd for sw).
- data_writeReg  out  32  writeback data.
- data_readRegA / data_readRegB  in  32  regfile read data, combinational.

## Operation
- Field layout: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2]; I-type imm[16:0], sign-extended to 32 bits.
- R-type (opcode 00000), rd = f(rs, rt). aluop 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll (rs << shamt), 00101 sra (rs >>> shamt, arithmetic).
- addi (00101): rd = rs + sext(imm).
- sw (00111): dmem[rs + sext(imm)] = $rd; ctrl_readRegB = rd; wren = 1; no regfile write.
- lw (01000): rd = q_dmem at address rs + sext(imm).
- Any other opcode or R-type aluop: no-op. wren = 0, ctrl_writeEnable = 0, PC still advances.
- Overflow is signed 32-bit two's-complement overflow of add/addi/sub. On overflow the result is discarded and r30 is written instead: ctrl_writeReg = 30, data_writeReg = 1 (add), 2 (addi), 3 (sub).
- Writes with destination 0 (non-overflow) drive ctrl_writeEnable = 0.
- ctrl_readRegA = rs for all instructions.
- address_dmem, data, ctrl_readRegA/B are driven from the decode for every instruction; their values are don't-care when unused.
- While reset = 1: wren = 0, ctrl_writeEnable = 0; other outputs follow decode of q_imem.

## Timing
- PC register is 12-bit. On a rising edge with reset = 1, PC <= 0; otherwise PC <= PC + 1, wrapping 4095 -> 0.
- Reset value: out_PC = address_imem = 0 after the first reset edge; in_PC = 0 while reset is high.
- Fetch, decode, execute, memory access and writeback-data generation are purely combinational within one cycle.
- The regfile and dmem commit writes at the same rising edge that advances the PC; one instruction retires per cycle, latency 1 cycle.
- No stalls, hazards or forwarding: each instruction sees the register state committed by the previous edge.
- Reset asserted mid-program: PC returns to 0 at the next edge; writes are suppressed during every reset-high cycle.

## Test plan
- Reset: hold reset 2 edges -> out_PC = address_imem = 0, wren = 0, ctrl_writeEnable = 0. Release reset -> PC steps 0,1,2 on successive edges; in_PC = out_PC+1.
- add r3,r1,r2 (0x00C22000) with A = 5, B = 7 -> ctrl_writeEnable = 1, ctrl_writeReg = 3, data_writeReg = 12. Repeat with A = 0x7FFFFFFF, B = 1 -> writeReg = 30, data = 1.
- sub (aluop 00001) with A = 0x80000000, B = 1 -> r30 = 3. sll shamt 4 of 0x1 -> 0x10. sra shamt 4 of 0xF0000000 -> 0xFF000000. and/or of 0xF0F0, 0x0FF0 -> 0x00F0 / 0xFFF0.
- addi rd = 4, rs = 1, imm = 0x1FFFF (-1), A = 10 -> data_writeReg = 9. A = 0x7FFFFFFF, imm = 1 -> r30 = 2.
- sw rd = 2, rs = 1, imm = 8, A = 4, B = 0xDEAD -> ctrl_readRegB = 2, address_dmem = 12, data = 0xDEAD, wren = 1, ctrl_writeEnable = 0. lw same address with q_dmem = 0xBEEF -> data_writeReg = 0xBEEF, wren = 0.
- PC wrap and illegal opcode: run from PC 4095 -> next PC 0. Opcode 11111 -> no writes, PC increments. add with rd = 0 -> ctrl_writeEnable = 0.
